// File: rtl/instr_fetch.sv
// instr_fetch: PC/fetch sequencer for a synchronous ROM with branch squash and halt.
// Optional retire counter enabled by defining INSTR_FETCH_COUNT_EN.
module instr_fetch (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [9:0]  StartAddr,
  output logic [9:0]  InstrAddr,
  input  logic [8:0]  InstrData,
  output logic [2:0]  Opcode,
  output logic [2:0]  Funct,
  output logic [2:0]  Operand,
  output logic        Valid,
  input  logic        Branch,
  input  logic        BranchCond,
  input  logic        Zero,
  input  logic [9:0]  BranchTarget,
  input  logic        Halt,
  output logic        Done,
  output logic [15:0] InstrCount
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, stateNext;
  logic [9:0] pc, pcNext;
  logic valid, validNext, taken;
  assign taken = valid & (Branch | (BranchCond & Zero));
  always_comb begin
    stateNext = state;
    pcNext = pc;
    validNext = 1'b0;
    if (state == RUN) begin
      if (valid & Halt) stateNext = HALTED;
      else if (taken) pcNext = BranchTarget;
      else begin
        pcNext = pc + 10'd1;
        validNext = 1'b1;
      end
    end else if (Start) begin
      stateNext = RUN;
      pcNext = StartAddr;
    end
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      pc <= '0;
      valid <= 1'b0;
    end else begin
      state <= stateNext;
      pc <= pcNext;
      valid <= validNext;
    end
  end
  assign InstrAddr = pc;
  assign Valid = valid;
  assign Done = state == HALTED;
  assign Opcode = valid ? InstrData[8:6] : 3'b010;
  assign Funct = valid ? InstrData[2:0] : 3'b111;
  assign Operand = valid ? InstrData[5:3] : 3'b000;
`ifdef INSTR_FETCH_COUNT_EN
  logic [15:0] count;
  logic retire, restart;
  assign retire = valid & ~Halt & (state == RUN);
  assign restart = Start & (state != RUN);
  always_ff @(posedge CLK) begin
    if (Reset || restart) count <= '0;
    else if (retire && count != 16'hFFFF) count <= count + 16'd1;
  end
  assign InstrCount = count;
`else
  assign InstrCount = '0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven cycle vectors plus hand sequences for reset mid-run and halt counting.
module tb_instr_fetch;
  logic CLK = 1'b0, Reset = 1'b1, Start = 1'b0, Branch = 1'b0, BranchCond = 1'b0, Zero = 1'b0, Halt = 1'b0;
  logic [9:0] StartAddr = '0, BranchTarget = '0, InstrAddr;
  logic [8:0] InstrData = '0;
  logic [2:0] Opcode, Funct, Operand;
  logic Valid, Done;
  logic [15:0] InstrCount;
  int errors = 0, checks = 0;

  instr_fetch dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .InstrAddr(InstrAddr),
    .InstrData(InstrData), .Opcode(Opcode), .Funct(Funct), .Operand(Operand), .Valid(Valid),
    .Branch(Branch), .BranchCond(BranchCond), .Zero(Zero), .BranchTarget(BranchTarget),
    .Halt(Halt), .Done(Done), .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] romWord(input logic [9:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd37 + 16'd11;
    return t[8:0];
  endfunction

  always @(posedge CLK) InstrData <= romWord(InstrAddr);

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int expCount(input int c);
`ifdef INSTR_FETCH_COUNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic chkOut(input string tag, input logic v, input logic [9:0] a, input logic [9:0] w,
                        input logic d, input int c);
    logic [8:0] x;
    x = romWord(w);
    chk({tag, ".valid"}, int'(Valid), int'(v));
    chk({tag, ".addr"}, int'(InstrAddr), int'(a));
    chk({tag, ".opcode"}, int'(Opcode), v ? int'(x[8:6]) : 2);
    chk({tag, ".funct"}, int'(Funct), v ? int'(x[2:0]) : 7);
    chk({tag, ".operand"}, int'(Operand), v ? int'(x[5:3]) : 0);
    chk({tag, ".done"}, int'(Done), int'(d));
    chk({tag, ".count"}, int'(InstrCount), expCount(c));
  endtask

  typedef struct {
    logic rst, start;
    logic [9:0] sAddr;
    logic br, bc, z;
    logic [9:0] tgt;
    logic halt;
    logic expV;
    logic [9:0] expA, expW;
    logic expD;
    int expC;
  } vec_t;

  vec_t vecs[22];

  initial begin
    vecs[0]  = '{0,1,5,   0,0,0,0,  0, 0,0,0,       0,0};
    vecs[1]  = '{0,0,0,   0,0,0,0,  0, 0,5,0,       0,0};
    vecs[2]  = '{0,0,0,   0,0,0,0,  0, 1,6,5,       0,0};
    vecs[3]  = '{0,0,0,   0,0,0,0,  0, 1,7,6,       0,1};
    vecs[4]  = '{0,0,0,   0,0,0,0,  0, 1,8,7,       0,2};
    vecs[5]  = '{0,0,0,   0,0,0,0,  0, 1,9,8,       0,3};
    vecs[6]  = '{0,0,0,   0,0,0,0,  0, 1,10,9,      0,4};
    vecs[7]  = '{0,0,0,   1,0,0,40, 0, 1,11,10,     0,5};
    vecs[8]  = '{0,1,100, 1,0,0,200,0, 0,40,0,      0,6};
    vecs[9]  = '{0,0,0,   0,0,0,0,  0, 1,41,40,     0,6};
    vecs[10] = '{0,0,0,   0,1,0,300,0, 1,42,41,     0,7};
    vecs[11] = '{0,0,0,   0,1,1,300,0, 1,43,42,     0,8};
    vecs[12] = '{0,0,0,   0,0,0,0,  0, 0,300,0,     0,9};
    vecs[13] = '{0,0,0,   1,0,0,500,1, 1,301,300,   0,9};
    vecs[14] = '{0,0,0,   0,0,0,0,  0, 0,301,0,     1,9};
    vecs[15] = '{0,1,1022,0,0,0,0,  0, 0,301,0,     1,9};
    vecs[16] = '{0,0,0,   0,0,0,0,  0, 0,1022,0,    0,0};
    vecs[17] = '{0,0,0,   0,0,0,0,  0, 1,1023,1022, 0,0};
    vecs[18] = '{0,0,0,   0,0,0,0,  0, 1,0,1023,    0,1};
    vecs[19] = '{1,1,9,   0,0,0,0,  0, 1,1,0,       0,2};
    vecs[20] = '{0,0,0,   0,0,0,0,  0, 0,0,0,       0,0};
    vecs[21] = '{0,0,0,   1,0,0,77, 0, 0,0,0,       0,0};

    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    for (int i = 0; i < 22; i++) begin
      Reset = vecs[i].rst; Start = vecs[i].start; StartAddr = vecs[i].sAddr;
      Branch = vecs[i].br; BranchCond = vecs[i].bc; Zero = vecs[i].z;
      BranchTarget = vecs[i].tgt; Halt = vecs[i].halt;
      chkOut($sformatf("vec%0d", i), vecs[i].expV, vecs[i].expA, vecs[i].expW, vecs[i].expD, vecs[i].expC);
      @(negedge CLK);
    end
    Reset = 1'b0; Start = 1'b0; Branch = 1'b0; BranchCond = 1'b0; Zero = 1'b0; Halt = 1'b0;
    chkOut("idleHold", 0, 0, 0, 0, 0);

    Start = 1'b1; StartAddr = 10'd32;
    @(negedge CLK);
    Start = 1'b0;
    begin
      int n = 0;
      while (InstrAddr != 10'd37 && n < 10) begin
        @(negedge CLK);
        n++;
      end
      chk("reachPc37", int'(InstrAddr), 37);
    end
    Reset = 1'b1; Start = 1'b1; StartAddr = 10'd99;
    @(negedge CLK);
    Reset = 1'b0; Start = 1'b0;
    chkOut("resetMidRun", 0, 0, 0, 0, 0);
    @(negedge CLK);
    chkOut("resetStaysIdle", 0, 0, 0, 0, 0);

    Start = 1'b1; StartAddr = 10'd32;
    @(negedge CLK);
    Start = 1'b0;
    begin
      int n = 0;
      while (InstrAddr != 10'd39 && n < 12) begin
        @(negedge CLK);
        n++;
      end
      chkOut("preHalt", 1, 39, 38, 0, 6);
    end
    Halt = 1'b1; Branch = 1'b1; BranchTarget = 10'd600;
    @(negedge CLK);
    Halt = 1'b0; Branch = 1'b0;
    chkOut("halted", 0, 39, 0, 1, 6);
    @(negedge CLK);
    chkOut("haltHold", 0, 39, 0, 1, 6);
    Start = 1'b1; StartAddr = 10'd0;
    @(negedge CLK);
    Start = 1'b0;
    chkOut("restart", 0, 0, 0, 0, 0);
    @(negedge CLK);
    chkOut("restartFirst", 1, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
